line_mem_prog: RTL
==================

Name: line_mem_prog

Overview:
- Clocked, loadable instruction memory that replaces the fixed-contents line store.
- A loader port writes program lines while the CPU is held off. A fetch port then returns the line at the instruction pointer with one-cycle registered latency and a valid strobe.
- The block detects the end-of-program marker and reads of unwritten or out-of-range lines, and reports halt/fault status to the CPU control unit.

Parameters:
LINE_WIDTH, 32, width of one program line
DEPTH, 256, number of lines held; need not be a power of two
IP_WIDTH, 8, instruction pointer width; must satisfy 2**IP_WIDTH >= DEPTH
END_LINE, 32'hffff_ffff, line value that halts the program

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  reset, synchronous, active-high
load_start  input  1  enter LOAD; clears valid bits and the line counter
load_we  input  1  write strobe, honoured only in LOAD
load_addr  input  IP_WIDTH  write address
load_data  input  LINE_WIDTH  line to write
load_done  input  1  leave LOAD and enter RUN
fetch_req  input  1  request the line at ip, honoured only in RUN
ip  input  IP_WIDTH  instruction pointer
line  output  LINE_WIDTH  fetched line, registered
line_valid  output  1  one-cycle pulse marking a new line
halted  output  1  END_LINE fetched; sticky
fault  output  1  bad fetch or bad write; sticky
fault_ip  output  IP_WIDTH  address of the first fault
lines_loaded  output  IP_WIDTH+1  count of distinct lines written since load_start
state_o  output  2  current state, for debug

Behaviour:
- State encoding: IDLE=0, LOAD=1, RUN=2, HALT=3.
- Reset, applied at the clock edge with rst=1:
  - state=IDLE; line=0; line_valid=0; halted=0; fault=0; fault_ip=0; lines_loaded=0.
  - All per-line valid bits cleared. Memory data array is not cleared.
- IDLE:
  - load_start -> LOAD.
  - load_done -> RUN with an empty program, so the first fetch faults.
  - fetch_req is ignored.
- LOAD:
  - Entry via load_start clears valid bits, lines_loaded, halted, fault and fault_ip.
  - load_we with load_addr<DEPTH: mem[addr]<=data and valid[addr]<=1. lines_loaded increments only if the line was not already valid. Rewriting a line overwrites the data and does not change the count.
  - load_we with load_addr>=DEPTH: no write; fault<=1; fault_ip<=load_addr if fault was 0.
  - load_done -> RUN. A load_we in the same cycle as load_done is still committed.
  - load_start while in LOAD restarts the load (clears again).
  - fetch_req is ignored.
- RUN:
  - Fetch latency: fetch_req sampled at edge N gives line and line_valid=1 at edge N+1. Back-to-back requests are allowed, one line per cycle.
  - ip<DEPTH and valid[ip]: line<=mem[ip].
  - ip>=DEPTH or !valid[ip]: line<=END_LINE; fault<=1; fault_ip<=ip if fault was 0.
  - A fetched line equal to END_LINE, including the fault case: halted<=1 on the same edge, state->HALT.
  - load_we is ignored.
  - load_start -> LOAD and aborts the run; no line_valid follows.
- HALT:
  - line holds its last value; line_valid=0; fetch_req is ignored.
  - Only load_start (-> LOAD) or rst leaves HALT.
- line_valid is 0 in every cycle without an accepted fetch. line holds its value between fetches.
- Priority: rst > load_start > load_done > load_we/fetch_req.
- fault and halted stay set until rst or load_start.
- Memory is a register array: synchronous write, read registered into line. No latches.

Decomposition:
- params.svh gains:
  - state enum lmp_state_t {IDLE, LOAD, RUN, HALT};
  - END_LINE;
  - the default LINE_WIDTH, DEPTH and IP_WIDTH.
- One natural sub-module, lmp_array: DEPTH x LINE_WIDTH storage plus the valid-bit vector, with one write port and one registered read port. It also returns the old valid bit on write, for the counter.
- The top level holds the FSM, the fault/halt logic and the counter.

Test Plan:
- Reset mid-RUN: load 4 lines, fetch ip=1, assert rst -> state=0, line=0, line_valid=0, lines_loaded=0. A later fetch is ignored.
- Multiply program: load lines 0..8 = 03000000, 03010000, 03020600, 03030500, 50080102, 00000003, 02010101, 40040000, ffffffff, then load_done.
  - Fetch ip=0..3 back-to-back -> line_valid high for 4 cycles carrying 03000000..03030500, each one cycle after its request.
  - Fetch ip=8 -> line=ffffffff, halted=1, state=3. Further fetch_req gives no pulse.
- Unwritten read: load lines 0..2 only, then fetch ip=5 -> line=ffffffff, fault=1, fault_ip=5, halted=1.
- Out-of-range with DEPTH=200, IP_WIDTH=8:
  - load_we at addr 210 -> fault=1, fault_ip=210, lines_loaded unchanged.
  - Fetch ip=250 in a fresh run -> fault, fault_ip=250.
- Overwrite and count: write addr 3 twice (data A then B) and addr 4 once -> lines_loaded=2; fetch ip=3 -> B.
- Simultaneous events:
  - load_we addr 7 with load_done in the same cycle -> write committed, state=RUN, fetch ip=7 returns the data.
  - load_start with fetch_req in RUN -> state=LOAD, no line_valid.

Source files
------------

// File: rtl/line_mem_prog_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// line_mem_prog_pkg : shared state type and default sizing for line_mem_prog
// rev 1.0
// ---------------------------------------------------------------------------
package line_mem_prog_pkg;

  localparam int          LMP_LINE_WIDTH = 32;
  localparam int          LMP_DEPTH      = 256;
  localparam int          LMP_IP_WIDTH   = 8;
  localparam logic [31:0] LMP_END_LINE   = 32'hffff_ffff;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } lmp_state_t;

endpackage
`default_nettype wire

// File: rtl/lmp_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lmp_array : program line storage with per-line valid bits, one write port
//             and one registered read port
// rev 1.0
// ---------------------------------------------------------------------------
module lmp_array #(
  parameter int                    LINE_WIDTH = 32,
  parameter int                    DEPTH      = 256,
  parameter int                    IP_WIDTH   = 8,
  parameter logic [LINE_WIDTH-1:0] FILL       = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr_valid,
  input  logic                  i_we,
  input  logic [IP_WIDTH-1:0]   i_waddr,
  input  logic [LINE_WIDTH-1:0] i_wdata,
  output logic                  o_wr_in_range,
  output logic                  o_wr_was_valid,
  input  logic                  i_re,
  input  logic [IP_WIDTH-1:0]   i_raddr,
  output logic                  o_rd_hit,
  output logic [LINE_WIDTH-1:0] o_rd_word,
  output logic [LINE_WIDTH-1:0] o_rd_line
);

  localparam int                C_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IP_WIDTH:0] C_DEPTH = (IP_WIDTH+1)'(DEPTH);

  logic [LINE_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [LINE_WIDTH-1:0] r_rd_line;

  logic                  w_win;
  logic                  w_rin;
  logic [C_AW-1:0]       w_widx;
  logic [C_AW-1:0]       w_ridx;

  // Index slices are only meaningful when the matching range flag is set.
  assign w_win  = ({1'b0, i_waddr} < C_DEPTH);
  assign w_rin  = ({1'b0, i_raddr} < C_DEPTH);
  assign w_widx = i_waddr[C_AW-1:0];
  assign w_ridx = i_raddr[C_AW-1:0];

  assign o_wr_in_range  = w_win;
  assign o_wr_was_valid = w_win && r_valid[w_widx];
  assign o_rd_hit       = w_rin && r_valid[w_ridx];
  assign o_rd_word      = w_rin ? r_mem[w_ridx] : '0;
  assign o_rd_line      = r_rd_line;

  always_ff @(posedge clk) begin
    if (i_we && w_win) begin
      r_mem[w_widx] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_clr_valid) begin
      r_valid <= '0;
    end else if (i_we && w_win) begin
      r_valid[w_widx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_line <= '0;
    end else if (i_re) begin
      r_rd_line <= o_rd_hit ? r_mem[w_ridx] : FILL;
    end
  end

endmodule
`default_nettype wire

// File: rtl/line_mem_prog.sv
`default_nettype none
// ---------------------------------------------------------------------------
// line_mem_prog : loadable instruction memory with registered fetch and
//                 halt/fault reporting
// rev 1.0
// ---------------------------------------------------------------------------
module line_mem_prog
  import line_mem_prog_pkg::*;
#(
  parameter int                    LINE_WIDTH = LMP_LINE_WIDTH,
  parameter int                    DEPTH      = LMP_DEPTH,
  parameter int                    IP_WIDTH   = LMP_IP_WIDTH,
  parameter logic [LINE_WIDTH-1:0] END_LINE   = LINE_WIDTH'(LMP_END_LINE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  load_we,
  input  logic [IP_WIDTH-1:0]   load_addr,
  input  logic [LINE_WIDTH-1:0] load_data,
  input  logic                  load_done,
  input  logic                  fetch_req,
  input  logic [IP_WIDTH-1:0]   ip,
  output logic [LINE_WIDTH-1:0] line,
  output logic                  line_valid,
  output logic                  halted,
  output logic                  fault,
  output logic [IP_WIDTH-1:0]   fault_ip,
  output logic [IP_WIDTH:0]     lines_loaded,
  output logic [1:0]            state_o
);

  lmp_state_t            r_state;
  lmp_state_t            w_state_nxt;

  logic                  r_line_valid;
  logic                  r_halted;
  logic                  r_fault;
  logic [IP_WIDTH-1:0]   r_fault_ip;
  logic [IP_WIDTH:0]     r_lines_loaded;

  logic                  w_clear;
  logic                  w_wr_en;
  logic                  w_fetch;
  logic                  w_wr_in_range;
  logic                  w_wr_was_valid;
  logic                  w_rd_hit;
  logic [LINE_WIDTH-1:0] w_rd_word;
  logic [LINE_WIDTH-1:0] w_fetch_line;
  logic                  w_fetch_end;
  logic                  w_bad;
  logic [IP_WIDTH-1:0]   w_bad_addr;

  lmp_array #(
    .LINE_WIDTH (LINE_WIDTH),
    .DEPTH      (DEPTH),
    .IP_WIDTH   (IP_WIDTH),
    .FILL       (END_LINE)
  ) u_array (
    .clk            (clk),
    .rst            (rst),
    .i_clr_valid    (w_clear),
    .i_we           (w_wr_en),
    .i_waddr        (load_addr),
    .i_wdata        (load_data),
    .o_wr_in_range  (w_wr_in_range),
    .o_wr_was_valid (w_wr_was_valid),
    .i_re           (w_fetch),
    .i_raddr        (ip),
    .o_rd_hit       (w_rd_hit),
    .o_rd_word      (w_rd_word),
    .o_rd_line      (line)
  );

  // A missing or out-of-range line reads as END_LINE, so a bad fetch also halts.
  assign w_fetch_line = w_rd_hit ? w_rd_word : END_LINE;
  assign w_fetch_end  = (w_fetch_line == END_LINE);
  assign w_bad        = (w_wr_en && !w_wr_in_range) || (w_fetch && !w_rd_hit);
  assign w_bad_addr   = w_fetch ? ip : load_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (load_start)     w_state_nxt = LOAD;
        else if (load_done) w_state_nxt = RUN;
      end
      LOAD: begin
        if (load_start)     w_state_nxt = LOAD;
        else if (load_done) w_state_nxt = RUN;
      end
      RUN: begin
        if (load_start)                  w_state_nxt = LOAD;
        else if (fetch_req && w_fetch_end) w_state_nxt = HALT;
      end
      HALT: begin
        if (load_start)     w_state_nxt = LOAD;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_clear = load_start;
    w_wr_en = 1'b0;
    w_fetch = 1'b0;
    state_o = r_state;
    if (!load_start) begin
      w_wr_en = (r_state == LOAD) && load_we;
      w_fetch = (r_state == RUN)  && fetch_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_line_valid   <= 1'b0;
      r_halted       <= 1'b0;
      r_fault        <= 1'b0;
      r_fault_ip     <= '0;
      r_lines_loaded <= '0;
    end else begin
      r_line_valid <= w_fetch;
      if (w_clear) begin
        r_halted       <= 1'b0;
        r_fault        <= 1'b0;
        r_fault_ip     <= '0;
        r_lines_loaded <= '0;
      end else begin
        if (w_wr_en && w_wr_in_range && !w_wr_was_valid) begin
          r_lines_loaded <= r_lines_loaded + (IP_WIDTH+1)'(1);
        end
        if (w_bad) begin
          r_fault <= 1'b1;
          if (!r_fault) begin
            r_fault_ip <= w_bad_addr;
          end
        end
        if (w_fetch && w_fetch_end) begin
          r_halted <= 1'b1;
        end
      end
    end
  end

  assign line_valid   = r_line_valid;
  assign halted       = r_halted;
  assign fault        = r_fault;
  assign fault_ip     = r_fault_ip;
  assign lines_loaded = r_lines_loaded;

endmodule
`default_nettype wire
